// File: rtl/itmult_seq_pkg.sv
// Shared constants for the itmult issue/collect sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package itmult_seq_pkg;

    // Sequencer states; encodings are fixed so waveforms and debug taps read the same everywhere.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    // Operand buffer depth. The buffer pointers are single bits, so this must stay at 2.
    localparam int OP_DEPTH = 2;

    // The RUN counter must reach SIZE+1 before the watchdog fires, with one bit of headroom.
    function automatic int run_cnt_w(input int size);
        return $clog2(size + 2) + 1;
    endfunction

endpackage

// File: rtl/op_fifo2.sv
// Two-entry operand FIFO with a fall-through path when empty.
// Latency: a push into an empty FIFO is visible on pop_dat in the same cycle.
// Backpressure: full is a decode of the registered count; the producer must not push while full.
//
// Ports: clk/reset (sync, active-high); push/push_dat write side; pop/pop_dat read side;
//        full/empty status, both derived from registered state only.
module op_fifo2 #(
    parameter int W     = 16,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;

    logic bypass;
    logic do_push;
    logic do_pop;

    assign empty = (count_q == 2'd0);
    assign full  = (count_q == 2'(DEPTH));

    // When empty, the incoming pair is handed straight through so the consumer
    // can start on the accept edge instead of one cycle later.
    assign pop_dat = empty ? push_dat : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // A same-cycle push and pop on an empty FIFO never touches storage.
        bypass  = empty && push && pop;
        do_push = push && !bypass;
        do_pop  = pop && !empty;

        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/itmult_seq.sv
// Issue/collect sequencer around the iterative shift-add multiplier, with a RUN watchdog.
// Latency: out_valid rises SIZE+2 cycles after the operand pair is accepted.
// Backpressure: in_ready drops while two pairs are buffered; the result holds until out_ready.
//
// Ports: clk, reset (sync, active-high, shared with the multiplier);
//        in_valid/in_ready/in_a/in_b   operand pair input handshake;
//        mul_a/mul_b/mul_start         drive to the multiplier (start 0 = load/hold, 1 = shift);
//        mul_hm/mul_lm/mul_fin         product halves and done flag from the multiplier;
//        out_valid/out_ready/out_hi/out_lo  result handshake; err sticky watchdog flag.
module itmult_seq
    import itmult_seq_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int DEPTH = OP_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_a,
    input  logic [SIZE-1:0] in_b,
    output logic [SIZE-1:0] mul_a,
    output logic [SIZE-1:0] mul_b,
    output logic            mul_start,
    input  logic [SIZE-1:0] mul_hm,
    input  logic [SIZE-1:0] mul_lm,
    input  logic            mul_fin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_hi,
    output logic [SIZE-1:0] out_lo,
    output logic            err
);

    localparam int                CNT_W     = run_cnt_w(SIZE);
    localparam logic [CNT_W-1:0]  RUN_LIMIT = CNT_W'(SIZE + 1);

    seq_state_t         state_q, state_d;
    logic [2*SIZE-1:0]  op_q, op_d;       // {a, b} currently owned by the multiplier
    logic [2*SIZE-1:0]  res_q, res_d;     // {hi, lo} captured product
    logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
    logic               err_q, err_d;

    logic               push;
    logic               pop;
    logic               have_op;
    logic [2*SIZE-1:0]  fifo_dat;
    logic               fifo_full;
    logic               fifo_empty;

    op_fifo2 #(
        .W     (2 * SIZE),
        .DEPTH (DEPTH)
    ) u_op_fifo2 (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat ({in_a, in_b}),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // in_ready depends only on registered FIFO occupancy, never on in_valid.
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    // A pair arriving this cycle counts as available, via the FIFO fall-through.
    assign have_op  = !fifo_empty || push;

    assign mul_a  = op_q[2*SIZE-1:SIZE];
    assign mul_b  = op_q[SIZE-1:0];
    assign out_hi = res_q[2*SIZE-1:SIZE];
    assign out_lo = res_q[SIZE-1:0];
    assign err    = err_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        res_d     = res_q;
        run_cnt_d = run_cnt_q;
        err_d     = err_q;
        pop       = 1'b0;
        mul_start = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (have_op) begin
                    pop     = 1'b1;
                    op_d    = fifo_dat;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // One cycle with start low lets the multiplier latch b and arm its counter.
                run_cnt_d = '0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                mul_start = 1'b1;
                if (mul_fin) begin
                    // The multiplier shifts once more on this edge; the product is already taken.
                    res_d   = {mul_hm, mul_lm};
                    state_d = ST_DONE;
                end else if (run_cnt_q == RUN_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (have_op) begin
                        pop     = 1'b1;
                        op_d    = fifo_dat;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            res_q     <= '0;
            run_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            res_q     <= res_d;
            run_cnt_q <= run_cnt_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: doc/itmult_seq.md
# itmult_seq

Issue-and-collect sequencer that sits on both sides of the iterative shift-add multiplier, `itmult`. It accepts operand pairs over a valid/ready handshake and buffers up to two pairs. For each pair it runs the multiplier's load/shift protocol on `mul_start`, watches `mul_fin`, and captures the 2·SIZE-bit product into an output register presented over valid/ready. A RUN-cycle watchdog flags a multiplier that never asserts `fin`.

## Interface
Parameters:
- SIZE, 8, operand width; product is 2·SIZE bits.
- DEPTH, 2, operand-buffer entries; fixed at 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset. It is also routed unchanged to the multiplier.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  buffer not full.
- in_a, in_b  in  SIZE  multiplicand, multiplier.
- mul_a, mul_b  out  SIZE  operands driven to the multiplier; held stable from LOAD through capture.
- mul_start  out  1  0 = load/hold, 1 = shift step.
- mul_hm, mul_lm  in  SIZE  multiplier high and low product halves.
- mul_fin  in  1  multiplier iteration counter empty.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts.
- out_hi, out_lo  out  SIZE  captured product halves.
- err  out  1  sticky watchdog flag.

## Operation
- **Buffer:** 2-entry FIFO of {a,b}.
  - Push when in_valid & in_ready.
  - Pop on IDLE→LOAD or DONE→LOAD.
  - Push and pop in the same cycle are both honoured. A push into a full buffer is impossible, because in_ready=0 when full.
- **FSM:** IDLE, LOAD, RUN, DONE.
- **IDLE:** mul_start=0. If the buffer is non-empty: pop into the operand register, go to LOAD.
- **LOAD:** mul_start=0 for exactly one cycle; the multiplier latches b and its counter loads 1. Next state is RUN, with run_cnt←0.
- **RUN:** mul_start=1.
  - If mul_fin=1: latch {mul_hm,mul_lm} into {out_hi,out_lo} and go to DONE.
  - Else if run_cnt==SIZE+1: set err, discard the operation, go to IDLE.
  - Else run_cnt+1.
  - mul_fin is sampled only in RUN; it is high out of reset and ignored in IDLE and LOAD.
- **DONE:** out_valid=1, mul_start=0. On out_valid & out_ready:
  - buffer non-empty → pop and go to LOAD;
  - otherwise → IDLE.
  - out_* stay stable while out_ready=0.
- **Reset:** synchronous. State IDLE, buffer empty, run_cnt 0. The outputs are: in_ready 1, out_valid 0, out_hi/out_lo 0, mul_a/mul_b 0, mul_start 0, err 0.
  - Reset in any state, including mid-RUN, abandons the operation with no output.
- **err:** cleared only by reset.
- **Arithmetic:** the block does none. The product is taken verbatim, unsigned.
- **run_cnt:** width is ⌈log2(SIZE+2)⌉+1.

## Timing
- The accept edge is E0.
  - LOAD occupies the cycle after E0.
  - RUN starts after E1.
  - The multiplier shifts on E2…E(SIZE+1), so mul_fin=1 after E(SIZE+1).
  - Capture happens on E(SIZE+2).
- **Latency:** out_valid rises SIZE+2 cycles after accept (10 for SIZE=8).
- **Throughput:** one result per SIZE+3 cycles with out_ready held high; the DONE→LOAD handoff takes 1 cycle.
- **Extra shift on capture:** the multiplier takes one extra shift on the capture edge. This is harmless because the product was already latched.
- **Watchdog:** err rises on E(SIZE+3) if fin never arrives.
- **in_ready:** registered function of buffer count. It reflects a pop on the same edge, so it is 1 in the cycle after a full buffer pops.
- No combinational path from in_valid to in_ready or from out_ready to out_valid.

## Structure
- Shared header of localparams holds:
  - the FSM encodings IDLE=0, LOAD=1, RUN=2, DONE=3;
  - the DEPTH constant;
  - the run_cnt width function.
- One sub-module, `op_fifo2`: 2-entry, 2·SIZE-wide FIFO with count, push, pop, full and empty.
  - FSM, operand register, result register and watchdog live in the top.
- The multiplier is instantiated by the parent beside this block, not inside it.

## Test plan
All scenarios use SIZE=8.
1. **Single op:** push 13×11 with out_ready=1 → out_valid 10 cycles after accept, out_hi=0, out_lo=143, err=0.
2. **Max operands:** push 255×255 → out_hi=254, out_lo=1.
3. **Back-to-back, buffer full:**
   - Push (3,5),(7,9),(200,100) on consecutive cycles; in_ready must drop for exactly the cycle the buffer holds 2 entries.
   - Results 15, 63, 20000 appear in order, spaced 11 cycles apart.
4. **Backpressure:** out_ready=0 for 5 cycles during DONE with a queued pair → out_* stable, mul_start=0, no LOAD until the handshake, then the next result is correct.
5. **Reset mid-RUN:** assert reset 4 cycles into RUN → next edge shows IDLE outputs, buffer empty. A subsequent 6×7 yields 42.
6. **Watchdog:** tie mul_fin=0 after LOAD → err=1 at accept+11, out_valid never asserts, in_ready=1. err persists until reset.
